// File: rtl/mips_pkg.sv
// Shared constants and the store-buffer entry type for the MIPS datapath.
// The entry carries everything needed to replay one store into dm_4k.
package mips_pkg;
    localparam int SB_DEPTH = 4;
    localparam int DM_IDXW  = 10;

    typedef struct packed {
        logic        is_byte;
        logic [31:0] addr;
        logic [31:0] data;
    } sb_entry_t;
endpackage

// File: rtl/sb_fifo.sv
// Circular FIFO of pending stores: entry array, head/tail pointers, occupancy count,
// plus per-entry valid bits and word indices for the load-hazard compare.
module sb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int IDXW  = DM_IDXW
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 push_i,
    input  sb_entry_t            push_ent_i,
    input  logic                 pop_i,
    output sb_entry_t            head_o,
    output logic [DEPTH-1:0]     vld_o,
    output logic [IDXW-1:0]      widx_o [DEPTH],
    output logic [$clog2(DEPTH):0] cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   hd_q, hd_d;
    logic [PW-1:0]   tl_q, tl_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        hd_d  = pop_i  ? hd_q + PW'(1) : hd_q;
        tl_d  = push_i ? tl_q + PW'(1) : tl_q;
        cnt_d = cnt_q;
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hd_q  <= '0;
            tl_q  <= '0;
            cnt_q <= '0;
        end else begin
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload is never cleared; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tl_q] <= push_ent_i;
        end
    end

    always_comb begin
        logic [PW-1:0] off;
        for (int i = 0; i < DEPTH; i++) begin
            off       = PW'(i) - hd_q;
            vld_o[i]  = {1'b0, off} < cnt_q;
            widx_o[i] = mem_q[i].addr[IDXW+1:2];
        end
    end

    assign head_o = mem_q[hd_q];
    assign cnt_o  = cnt_q;

    cnt_bounds_a: assert property (@(posedge clk) disable iff (clr)
        (cnt_q <= CW'(DEPTH)) && !(pop_i && cnt_q == '0) && !(push_i && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/store_buf.sv
// Store buffer in front of dm_4k: queues sw/sb, retires one per cycle in order,
// lets safe loads take the shared port and stalls loads that hit a pending word.
module store_buf
    import mips_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int IDXW  = DM_IDXW
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        st_req,
    input  logic        st_byte,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    input  logic        ld_req,
    input  logic        ld_byte,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_wr,
    output logic        dm_byte,
    output logic        empty
);
    localparam int CW = $clog2(DEPTH) + 1;

    sb_entry_t        push_ent;
    sb_entry_t        head;
    logic [DEPTH-1:0] vld;
    logic [IDXW-1:0]  widx [DEPTH];
    logic [CW-1:0]    cnt;
    logic             full;
    logic             push;
    logic             hazard;
    logic             drain;

    assign push_ent = '{is_byte: st_byte, addr: st_addr, data: st_data};
    assign push     = st_req & st_ready;

    sb_fifo #(.DEPTH(DEPTH), .IDXW(IDXW)) u_fifo (
        .clk        (clk),
        .clr        (clr),
        .push_i     (push),
        .push_ent_i (push_ent),
        .pop_i      (drain),
        .head_o     (head),
        .vld_o      (vld),
        .widx_o     (widx),
        .cnt_o      (cnt)
    );

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign st_ready = ~full;

    // Word-granular match: a different byte lane in the same word still hazards.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && widx[i] == ld_addr[IDXW+1:2]) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & ld_req;
    end

    assign drain    = ~empty & (~ld_req | hazard | full);
    assign ld_stall = ld_req & (hazard | full);

    always_comb begin
        if (drain) begin
            dm_wr   = 1'b1;
            dm_addr = head.addr;
            dm_din  = head.data;
            dm_byte = head.is_byte;
        end else begin
            dm_wr   = 1'b0;
            dm_addr = ld_addr;
            dm_din  = '0;
            dm_byte = ld_byte;
        end
    end
endmodule

// File: tb/tb_store_buf.sv
// Randomized and directed bench for store_buf against a queue-based reference
// of pending stores and a word-array memory standing in for dm_4k.
module tb_store_buf;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        st_req, st_byte, st_ready;
    logic [31:0] st_addr, st_data;
    logic        ld_req, ld_byte, ld_stall;
    logic [31:0] ld_addr;
    logic [31:0] dm_addr, dm_din;
    logic        dm_wr, dm_byte, empty;

    int total = 0;
    int bad   = 0;

    store_buf #(.DEPTH(DEPTH), .IDXW(10)) dut (
        .clk(clk), .clr(clr),
        .st_req(st_req), .st_byte(st_byte), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready),
        .ld_req(ld_req), .ld_byte(ld_byte), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_wr(dm_wr), .dm_byte(dm_byte),
        .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        b;
        logic [31:0] a;
        logic [31:0] d;
    } st_t;

    st_t         pend[$];
    logic [31:0] mem  [1024];
    logic [31:0] refm [1024];
    logic [31:0] dout;

    function automatic logic [31:0] merge(input logic [31:0] w, input logic b,
                                          input logic [1:0] lane, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (b) r[lane*8 +: 8] = d[7:0];
        else   r = d;
        return r;
    endfunction

    function automatic logic [31:0] rd_ext(input logic [31:0] w, input logic b,
                                           input logic [1:0] lane);
        logic [7:0] x;
        x = w[lane*8 +: 8];
        return b ? {{24{x[7]}}, x} : w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always_comb dout = rd_ext(mem[dm_addr[11:2]], dm_byte, dm_addr[1:0]);

    logic        w_en, w_b;
    logic [31:0] w_a, w_d;
    logic        e_drain, e_push;

    initial begin
        w_en = 1'b0; e_drain = 1'b0; e_push = 1'b0;
        w_b = 1'b0; w_a = '0; w_d = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = '0;
            refm[i] = '0;
        end
    end

    // Monitor: expected port behaviour from the pending-store queue.
    always @(negedge clk) begin
        logic        haz, full;
        logic [31:0] w;
        full = (pend.size() == DEPTH);
        haz  = 1'b0;
        foreach (pend[i]) if (pend[i].a[11:2] == ld_addr[11:2]) haz = ld_req;
        e_drain = (pend.size() != 0) && (!ld_req || haz || full);
        e_push  = st_req && !full && !clr;
        chk("st_ready", st_ready, !full);
        chk("empty", empty, pend.size() == 0);
        chk("ld_stall", ld_stall, ld_req && (haz || full));
        chk("dm_wr", dm_wr, e_drain);
        if (e_drain) begin
            chk("wr_addr", dm_addr, pend[0].a);
            chk("wr_data", dm_din, pend[0].d);
            chk("wr_byte", dm_byte, pend[0].b);
        end else begin
            chk("rd_addr", dm_addr, ld_addr);
            chk("rd_byte", dm_byte, ld_byte);
            chk("rd_din", dm_din, 0);
        end
        if (ld_req && !ld_stall && !clr) begin
            w = refm[ld_addr[11:2]];
            foreach (pend[i]) if (pend[i].a[11:2] == ld_addr[11:2]) w = merge(w, pend[i].b, pend[i].a[1:0], pend[i].d);
            chk("ld_data", dout, rd_ext(w, ld_byte, ld_addr[1:0]));
        end
        w_en = dm_wr; w_a = dm_addr; w_d = dm_din; w_b = dm_byte;
    end

    always @(posedge clk) begin
        if (!clr) begin
            if (w_en) mem[w_a[11:2]] <= merge(mem[w_a[11:2]], w_b, w_a[1:0], w_d);
            if (e_drain && pend.size() != 0) begin
                refm[pend[0].a[11:2]] = merge(refm[pend[0].a[11:2]], pend[0].b, pend[0].a[1:0], pend[0].d);
                void'(pend.pop_front());
            end
            if (e_push) pend.push_back('{b: st_byte, a: st_addr, d: st_data});
        end
    end

    always @(posedge clr) pend.delete();

    task automatic idle(input int n);
        st_req = 1'b0;
        ld_req = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic hold_ld(input logic [31:0] a);
        ld_req = 1'b1; ld_byte = 1'b0; ld_addr = a;
    endtask

    task automatic do_store(input logic b, input logic [31:0] a, input logic [31:0] d);
        logic rdy, done;
        st_req = 1'b1; st_byte = b; st_addr = a; st_data = d;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk); rdy = st_ready;
            @(posedge clk); #1;
            done = rdy;
        end
        st_req = 1'b0;
        if (!done) chk("store_timeout", 0, 1);
    endtask

    task automatic do_load(input logic b, input logic [31:0] a, output int stalls,
                           output logic [31:0] d);
        logic done;
        ld_req = 1'b1; ld_byte = b; ld_addr = a;
        stalls = 0; done = 1'b0; d = '0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!ld_stall) begin
                done = 1'b1;
                d = dout;
            end else stalls++;
            @(posedge clk); #1;
        end
        ld_req = 1'b0;
        if (!done) chk("load_timeout", 0, 1);
    endtask

    initial begin
        int          s;
        logic [31:0] d;
        clr = 1'b1; st_req = 1'b0; st_byte = 1'b0; st_addr = '0; st_data = '0;
        ld_req = 1'b0; ld_byte = 1'b0; ld_addr = '0;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_ready", st_ready, 1);
        chk("rst_dm_wr", dm_wr, 0);
        @(posedge clk); #1; clr = 1'b0;

        // In-order retirement with a byte merge.
        do_store(1'b0, 32'h100, 32'h11223344);
        do_store(1'b1, 32'h101, 32'h000000AA);
        idle(2);
        do_load(1'b0, 32'h100, s, d);
        chk("order_stall", s, 0);
        chk("order_data", d, 32'h1122AA44);

        // Hazard drains up to the youngest matching entry only.
        hold_ld(32'h800);
        do_store(1'b0, 32'h200, 32'hA0A0A0A0);
        do_store(1'b0, 32'h300, 32'hB1B2B3B4);
        do_store(1'b0, 32'h204, 32'hC0C0C0C0);
        do_load(1'b0, 32'h300, s, d);
        chk("haz_stall", s, 2);
        chk("haz_data", d, 32'hB1B2B3B4);
        chk("haz_pending", empty, 0);
        idle(2);

        // Full buffer: one-cycle stall while the head drains.
        hold_ld(32'h800);
        for (int i = 0; i < 4; i++) do_store(1'b0, 32'h600 + 4*i, 32'h6000 + i);
        @(negedge clk);
        chk("full_ready", st_ready, 0);
        chk("full_stall", ld_stall, 1);
        chk("full_wr", dm_wr, 1);
        @(posedge clk); #1;
        chk("full_ready_back", st_ready, 1);
        idle(5);

        // Push and pop together keep occupancy at two while the pointers wrap.
        hold_ld(32'h800);
        do_store(1'b0, 32'h500, 32'h55000000);
        do_store(1'b0, 32'h504, 32'h55000001);
        ld_req = 1'b0;
        for (int i = 2; i < 8; i++) do_store(1'b0, 32'h500 + 4*i, 32'h55000000 + i);
        chk("pp_not_empty", empty, 0);
        idle(3);
        for (int i = 0; i < 8; i++) begin
            do_load(1'b0, 32'h500 + 4*i, s, d);
            chk("pp_data", d, 32'h55000000 + i);
        end

        // Byte-lane hazard: different lane, same word.
        do_store(1'b0, 32'h400, 32'h000000F0);
        idle(2);
        do_store(1'b1, 32'h403, 32'h0000007F);
        do_load(1'b1, 32'h400, s, d);
        chk("lane_stall", s, 1);
        chk("lane_data", d, 32'hFFFFFFF0);
        idle(2);

        // Reset with three stores pending: nothing reaches memory afterwards.
        hold_ld(32'h800);
        do_store(1'b0, 32'h700, 32'hDEAD0001);
        do_store(1'b0, 32'h704, 32'hDEAD0002);
        do_store(1'b0, 32'h708, 32'hDEAD0003);
        #1 clr = 1'b1;
        #1;
        chk("clr_empty", empty, 1);
        chk("clr_dm_wr", dm_wr, 0);
        chk("clr_ready", st_ready, 1);
        chk("clr_stall", ld_stall, 0);
        @(posedge clk); #1;
        clr = 1'b0; ld_req = 1'b0;
        idle(4);
        do_load(1'b0, 32'h704, s, d);
        chk("clr_discard", d, 0);

        // Random mix over a small address window so hazards are frequent.
        for (int n = 0; n < 400; n++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = 32'h40 + ($urandom_range(0, 7) << 2);
            if (r < 5) begin
                if ($urandom_range(0, 1) == 1) hold_ld(32'h900);
                else ld_req = 1'b0;
                if ($urandom_range(0, 1) == 1) do_store(1'b1, a + $urandom_range(0, 3), $urandom);
                else do_store(1'b0, a, $urandom);
            end else if (r < 8) begin
                if ($urandom_range(0, 1) == 1) do_load(1'b1, a + $urandom_range(0, 3), s, d);
                else do_load(1'b0, a, s, d);
            end else begin
                idle(1);
            end
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/store_buf.md
# store_buf

Four-entry store buffer between the MEM-stage control and `dm_4k`. It accepts word and byte stores from the pipeline and retires them to the data memory one per cycle in order. Loads use the shared `dm_4k` address port and win arbitration whenever it is safe. Loads that would read a word with a pending store stall until that store has retired.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; a power of two, at least 2.
- `IDXW`, 10: word-index width, matching `dm_4k` `addr[11:2]`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `clr` in 1: reset; asynchronous, active-high.
- `st_req` in 1: store request from the MEM stage.
- `st_byte` in 1: 1 for a byte store (`sb`), 0 for a word store (`sw`).
- `st_addr` in 32: store byte address.
- `st_data` in 32: store data; only bits 7:0 are meaningful for a byte store.
- `st_ready` out 1: entry available; a store is accepted on the edge where `st_req & st_ready`.
- `ld_req` in 1: load request from the MEM stage.
- `ld_byte` in 1: load size, forwarded to `dm_4k` `byte`.
- `ld_addr` in 32: load byte address.
- `ld_stall` out 1: the load cannot complete this cycle; the pipeline holds.
- `dm_addr` out 32: drives `dm_4k` `addr`.
- `dm_din` out 32: drives `dm_4k` `din`.
- `dm_wr` out 1: drives `dm_4k` `DMWr`.
- `dm_byte` out 1: drives `dm_4k` `byte`.
- `empty` out 1: no pending stores (used by `syscall` and halt logic).

## Operation
- **Storage.** The buffer is a circular FIFO with head pointer `hd` and tail pointer `tl`, each `log2(DEPTH)` bits wide, plus a `cnt` counter 0..`DEPTH`. Each entry holds `{byte, addr[31:0], data[31:0]}`.
- **Ready and empty.** `st_ready = (cnt != DEPTH)`. `empty = (cnt == 0)`.
- **Enqueue.** When `st_req & st_ready`, the store is written at `tl`.
  - An enqueue is refused when `cnt == DEPTH`, even if a drain occurs in the same cycle.
  - Upstream must hold `st_req` and its data until `st_ready` is high.
- **Hazard.** `hazard` is 1 when `ld_req` is high and any valid entry has `addr[IDXW+1:2] == ld_addr[IDXW+1:2]`.
  - The comparison is at word granularity, so byte-lane differences within a word still count as a hazard.
  - Entries enqueued in the current cycle are not included.
- **Arbitration (combinational).** A drain happens when `cnt != 0` and any of these holds: `!ld_req`, `hazard`, or `cnt == DEPTH`.
- **`ld_stall`** `= ld_req & (hazard | cnt == DEPTH)`.
- **Port mux.** On a drain cycle the `dm_*` outputs take the head entry: `dm_wr = 1`, `dm_addr = head.addr`, `dm_din = head.data`, `dm_byte = head.byte`. On any other cycle: `dm_wr = 0`, `dm_addr = ld_addr`, `dm_byte = ld_byte`, `dm_din = 0`.
- **Load data.** Load data is taken directly from `dm_4k` `dout` in any cycle where `ld_req & !ld_stall`.
- **Drain advance.** Each drain increments `hd` on the clock edge and decrements `cnt`. With a simultaneous enqueue, `cnt` is unchanged.
- **Pointer wrap.** Pointers wrap modulo `DEPTH`.
- **Invariant.** `cnt` never exceeds `DEPTH` and never underflows; an assertion checks this in simulation.
- **Ordering.** Stores retire to memory in acceptance order, with no merging.

## Timing
- **Reset.** `clr` asynchronously clears `hd`, `tl` and `cnt`. Entry payload is not cleared.
  - Outputs during reset: `st_ready = 1`, `empty = 1`, `dm_wr = 0`, `ld_stall = 0`. `dm_addr` and `dm_byte` follow the load inputs; `dm_din = 0`.
  - Stores pending when `clr` asserts are discarded, and any drain in flight is cancelled.
- **Enqueue to drain.** An accepted store can drain at the earliest in the next cycle, giving one cycle of enqueue-to-memory-write latency.
- **Drain write.** `dm_4k` commits the write on the same rising edge that advances `hd`.
- **Hazard stall.** A load stalls for exactly the number of cycles needed to drain every entry up to and including the youngest matching entry.
- **Full stall.** When `cnt == DEPTH` and `ld_req` is high with no hazard, the load stalls for exactly one cycle.
- **Combinational paths.** `dm_*` outputs and `ld_stall` are combinational from state and from the `ld_*` inputs. There is no registered output stage.

## Structure
- **Shared package** (`mips_pkg`): `SB_DEPTH = 4`, `DM_IDXW = 10`, and the packed entry type `sb_entry_t {byte, addr, data}`.
- **Sub-module `sb_fifo`:** entry array, pointers, `cnt`, push/pop interface, and a per-entry valid vector exported for the hazard compare.
- **Top level `store_buf`:** instantiates `sb_fifo` and contains the hazard compare, arbitration and port mux.

## Test plan
- **Reset.** Assert `clr` mid-cycle with 3 entries pending -> immediately `cnt = 0`, `empty = 1`, `dm_wr = 0`; after release, no write from the old entries ever reaches `dm_4k`.
- **Order.** `sw 0x100 = 0x11223344`, then `sb 0x101 = 0xAA`, with no loads -> `dm_wr` on 2 consecutive cycles; then `lw 0x100` returns `0x1122AA44` with no stall.
- **Hazard.** With stores at `0x200`, `0x300` and `0x204` buffered, `lw 0x300` -> `ld_stall` high for 2 cycles (drains `0x200`, `0x300`), then the load completes with the value stored at `0x300`; `0x204` stays pending.
- **Full.** Issue 4 stores while `ld_req` is held on a non-matching address -> `st_ready = 0` after the 4th store. The next cycle shows `ld_stall = 1` and `dm_wr = 1`, and `st_ready` returns to 1 after that edge.
- **Concurrent push/pop.** With `cnt = 2` and no load, a store in each of 6 cycles -> `cnt` stays at 2, pointers wrap past `DEPTH`, and memory contents match the reference model in order.
- **Byte-lane hazard.** `sb 0x403 = 0x7F` pending, then `lb 0x400` -> stalls 1 cycle even though the lanes differ; the load then returns the correct sign-extended byte from offset 0.
